// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  // Responder state machine encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Default address map.
  localparam logic [31:0] DMEM_BASE   = 32'h2000_0000;
  localparam logic [31:0] DMEM_TOHOST = 32'h2000_1000;

  // Replace each byte lane of old_word whose enable bit is set with the
  // matching lane of new_word.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with byte-lane writes and a registered
// read port. A read updates rdata only when enabled, so the word fetched at
// accept stays on rdata until the next access.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Lane-merged write or word read, one access per enabled edge.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= be_merge(mem[addr], wdata, be);
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: one request outstanding, response LATENCY cycles after
// accept, plus an optional memory-mapped tohost register (DMEM_TOHOST_EN).
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high; the requester holds its fields stable until then.
// rsp_valid is a one-cycle pulse with rsp_rdata/rsp_err valid in that cycle
// only (both are 0 otherwise).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE,
  parameter logic [31:0] TOHOST_ADDR = DMEM_TOHOST,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] tohost,
  output logic        tohost_valid,
  output logic [1:0]  fsm_state
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
  localparam logic [2:0]  CNT_START = 3'(LATENCY - 1);

  dmem_state_t state, state_n;
  logic [2:0]  cnt, cnt_n;

  logic [31:0] offset;
  logic        in_range;
  logic        is_tohost;
  logic        accept;

  // Response bookkeeping captured at accept.
  logic        sel_arr_q;
  logic [31:0] word_q;
  logic        err_q;
  logic [31:0] arr_rdata;

  // Unsigned offset compare also rejects addresses below the base (wrap).
  assign offset   = req_addr - BASE_ADDR;
  assign in_range = (offset < SPAN);
  assign accept   = req_valid && req_ready;

  assign req_ready = n_rst && (state == IDLE);
  assign fsm_state = state;

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic: WAIT counts LATENCY-1 down to 1, then RESP for one cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY > 1) begin
            state_n = WAIT;
            cnt_n   = CNT_START;
          end else begin
            state_n = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt <= 3'd1) state_n = RESP;
        else             cnt_n   = cnt - 3'd1;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .en    (accept && in_range),
    .we    (req_we),
    .be    (req_be),
    .addr  (offset[AW+1:2]),
    .wdata (req_wdata),
    .rdata (arr_rdata)
  );

`ifdef DMEM_TOHOST_EN
  logic [31:0] tohost_q;
  logic        tohost_v_q;

  assign is_tohost    = (req_addr[31:2] == TOHOST_ADDR[31:2]);
  assign tohost       = tohost_q;
  assign tohost_valid = tohost_v_q;

  // tohost takes the full word on any store to its address; valid is sticky.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      tohost_q   <= 32'd0;
      tohost_v_q <= 1'b0;
    end else if (accept && req_we && is_tohost) begin
      tohost_q   <= req_wdata;
      tohost_v_q <= 1'b1;
    end
  end
`else
  assign is_tohost    = 1'b0;
  assign tohost       = 32'd0;
  assign tohost_valid = 1'b0;
`endif

  // Snapshot the response source at accept: array word, tohost word or zero.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sel_arr_q <= 1'b0;
      word_q    <= 32'd0;
      err_q     <= 1'b0;
    end else if (accept) begin
      sel_arr_q <= in_range && !req_we;
      word_q    <= (is_tohost && !req_we) ? tohost : 32'd0;
      err_q     <= !in_range && !is_tohost;
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_rdata = (state == RESP) ? (sel_arr_q ? arr_rdata : word_q) : 32'd0;
  assign rsp_err   = (state == RESP) ? err_q : 1'b0;

endmodule
